// File: rtl/io_pkg.sv
// Shared types and constants for the CPU output capture buffer.
package io_pkg;

  localparam int IO_WIDTH = 24;
  localparam int IO_TOTAL = 750;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } io_state_t;

endpackage

// File: rtl/io_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner's level count.
module io_fifo_mem #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/io_out_buffer.sv
// Captures TOTAL CPU output words into a show-ahead FIFO, drains them to a
// downstream consumer, then holds done until reset.
module io_out_buffer
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = 16,
  parameter int TOTAL = IO_TOTAL
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     startIO,
  input  logic                     outFlag,
  input  logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         bufData,
  output logic                     bufValid,
  input  logic                     bufReady,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              captured,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  io_state_t         state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [15:0]       captured_q, captured_d;
  logic              overflow_q, overflow_d;
  logic              full, push, pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    captured_d = captured_q;
    overflow_d = overflow_q;

    full = (level_q == LW'(DEPTH));
    pop  = (state_q != IDLE) && (level_q != '0) && bufReady;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push = (state_q == CAPTURE) && outFlag && (!full || pop);

    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      captured_d = captured_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if ((state_q == CAPTURE) && outFlag && full && !pop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (startIO) state_d = CAPTURE;
      CAPTURE: if (push && (captured_q == 16'(TOTAL - 1))) state_d = DRAIN;
      DRAIN:   if (level_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
    end
  end

  io_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (out),
    .rd_addr (rd_ptr_q),
    .rd_data (bufData)
  );

  assign bufValid = (level_q != '0);
  assign level    = level_q;
  assign captured = captured_q;
  assign overflow = overflow_q;
  assign done     = (state_q == DONE);

endmodule
